nios_ii_nios2_gen2_0_cpu_div_cell: RTL and testbench

//  Iterative radix-2 restoring divider for the Nios II CPU execute/memory stages.
//  It is the inverse partner of the 16x16 partial-product multiply cell and backs divu/div.
//  The pipeline launches one divide per go pulse and stalls on M_div_stall.
//  The pipeline then captures the quotient and remainder on the one-cycle M_div_done pulse.

---
 rtl/nios_ii_nios2_gen2_0_cpu_div_cell.sv | 184 ++++++++++++++++++
 tb/tb_nios_ii_nios2_gen2_0_cpu_div_cell.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_ii_nios2_gen2_0_cpu_div_cell.sv
// Iterative radix-2 restoring divider backing divu/div.
// One result bit per ITER cycle; sign fix-up and special cases resolved in FIX.
module nios_ii_nios2_gen2_0_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_div_go,
    input  logic             E_div_signed,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    output logic             M_div_stall,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_t;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];
    assign rem_t = {rem_q, quo_q[WIDTH-1]};
    assign q_fix = qneg_q ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        accept  = E_div_go & ((state_q == S_IDLE) | (state_q == S_DONE));

        // Operands are captured raw on the accepting edge; DONE may relaunch.
        if (accept) begin
            a_d   = E_src1;
            b_d   = E_src2;
            sgn_d = E_div_signed;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_PREP;
            end
            S_PREP: begin
                quo_d   = a_neg ? -a_q : a_q;
                div_d   = b_neg ? -b_q : b_q;
                rem_d   = '0;
                cnt_d   = '0;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dz_d    = (b_q == '0);
                ovf_d   = sgn_q & (a_q == MIN) & (b_q == '1);
                zero_d  = (a_q == '0);
                state_d = S_ITER;
            end
            S_ITER: begin
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
                // The true difference is below the divisor, so W-bit wrap is exact.
                if (rem_t >= {1'b0, div_q}) begin
                    rem_d    = rem_t[WIDTH-1:0] - div_q;
                    quo_d[0] = 1'b1;
                end else begin
                    rem_d = rem_t[WIDTH-1:0];
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    quot_d = '1;
                    remo_d = a_q;
                end else if (ovf_q) begin
                    quot_d = MIN;
                    remo_d = '0;
                end else if (zero_q) begin
                    quot_d = '0;
                    remo_d = '0;
                end else begin
                    quot_d = q_fix;
                    remo_d = r_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = accept ? S_PREP : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign M_div_stall = (state_q == S_PREP) |
                         (state_q == S_ITER) |
                         (state_q == S_FIX);
    assign M_div_done  = (state_q == S_DONE);
    assign M_div_quot  = quot_q;
    assign M_div_rem   = remo_q;

endmodule

// File: tb/tb_nios_ii_nios2_gen2_0_cpu_div_cell.sv
// Self-checking bench for the iterative divider cell.
// Directed scenarios plus a randomized sweep against an arithmetic model.
module tb_nios_ii_nios2_gen2_0_cpu_div_cell;

    localparam logic [31:0] MIN = 32'h8000_0000;
    localparam logic [31:0] MAX = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        sgn;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        stall;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;

    int checks   = 0;
    int failures = 0;

    nios_ii_nios2_gen2_0_cpu_div_cell #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .E_div_go     (go),
        .E_div_signed (sgn),
        .E_src1       (s1),
        .E_src2       (s2),
        .M_div_stall  (stall),
        .M_div_done   (done),
        .M_div_quot   (quot),
        .M_div_rem    (rem)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic sg, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN && b == 32'hFFFF_FFFF) begin
            q = MIN;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    task automatic start_go(input logic sg, input logic [31:0] a,
                            input logic [31:0] b);
        go  = 1'b1;
        sgn = sg;
        s1  = a;
        s2  = b;
        @(posedge clk);
        #1;
        go  = 1'b0;
        sgn = 1'($urandom);
        s1  = $urandom;
        s2  = $urandom;
    endtask

    task automatic wait_done(input int pulse_at, output int lat,
                             output int bad, output logic [31:0] q,
                             output logic [31:0] r,
                             output logic [31:0] hq);
        lat = -1;
        bad = 0;
        q   = '0;
        r   = '0;
        hq  = '0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 5) hq = quot;
            if (j == pulse_at) begin
                go  = 1'b1;
                sgn = 1'b1;
                s1  = $urandom;
                s2  = $urandom;
            end else if (j == pulse_at + 1) begin
                go = 1'b0;
            end
            if (done === 1'b1) begin
                lat = j;
                q   = quot;
                r   = rem;
                if (stall !== 1'b0) bad++;
                break;
            end
            if (stall !== 1'b1) bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = 1'b0;
        sgn   = 1'b0;
        s1    = '0;
        s2    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (quot !== 32'd0) begin failures++; $display("FAIL reset_quot got=%h exp=0", quot); end
        if (rem !== 32'd0) begin failures++; $display("FAIL reset_rem got=%h exp=0", rem); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", stall); end
        if (done !== 1'b0) begin failures++; $display("FAIL idle_done got=%b exp=0", done); end
    endtask

    task automatic test_unsigned();
        int lat, bad;
        logic [31:0] q, r, hq;
        start_go(1'b0, 32'd100, 32'd7);
        wait_done(0, lat, bad, q, r, hq);
        checks += 4;
        if (lat !== 35) begin failures++; $display("FAIL u100_7_latency got=%0d exp=35", lat); end
        if (bad !== 0) begin failures++; $display("FAIL u100_7_stall badcycles=%0d exp=0", bad); end
        if (q !== 32'd14) begin failures++; $display("FAIL u100_7_quot got=%h exp=%h", q, 32'd14); end
        if (r !== 32'd2) begin failures++; $display("FAIL u100_7_rem got=%h exp=%h", r, 32'd2); end
    endtask

    task automatic test_signed();
        logic [31:0] ta[2] = '{32'hFFFF_FFF9, 32'd7};
        logic [31:0] tb[2] = '{32'd2, 32'hFFFF_FFFE};
        logic [31:0] eq[2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD};
        logic [31:0] er[2] = '{32'hFFFF_FFFF, 32'd1};
        int lat, bad;
        logic [31:0] q, r, hq;
        for (int i = 0; i < 2; i++) begin
            start_go(1'b1, ta[i], tb[i]);
            wait_done(0, lat, bad, q, r, hq);
            checks += 3;
            if (lat !== 35) begin failures++; $display("FAIL signed%0d_latency got=%0d exp=35", i, lat); end
            if (q !== eq[i]) begin failures++; $display("FAIL signed%0d_quot got=%h exp=%h", i, q, eq[i]); end
            if (r !== er[i]) begin failures++; $display("FAIL signed%0d_rem got=%h exp=%h", i, r, er[i]); end
        end
    endtask

    task automatic test_special();
        logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ta[5] = '{32'h1234, 32'h8000_1234, MIN, 32'd0, 32'd0};
        logic [31:0] tb[5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd5};
        logic [31:0] eq[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, MIN, 32'd0, 32'd0};
        logic [31:0] er[5] = '{32'h1234, 32'h8000_1234, 32'd0, 32'd0, 32'd0};
        int lat, bad;
        logic [31:0] q, r, hq;
        for (int i = 0; i < 5; i++) begin
            start_go(ts[i], ta[i], tb[i]);
            wait_done(0, lat, bad, q, r, hq);
            checks += 3;
            if (lat !== 35) begin failures++; $display("FAIL special%0d_latency got=%0d exp=35", i, lat); end
            if (q !== eq[i]) begin failures++; $display("FAIL special%0d_quot got=%h exp=%h", i, q, eq[i]); end
            if (r !== er[i]) begin failures++; $display("FAIL special%0d_rem got=%h exp=%h", i, r, er[i]); end
        end
    endtask

    task automatic test_ignored_go();
        int lat, bad;
        logic [31:0] q, r, hq;
        start_go(1'b0, 32'd1000, 32'd3);
        wait_done(10, lat, bad, q, r, hq);
        checks += 4;
        if (lat !== 35) begin failures++; $display("FAIL ignored_go_latency got=%0d exp=35", lat); end
        if (bad !== 0) begin failures++; $display("FAIL ignored_go_stall badcycles=%0d exp=0", bad); end
        if (q !== 32'd333) begin failures++; $display("FAIL ignored_go_quot got=%h exp=%h", q, 32'd333); end
        if (r !== 32'd1) begin failures++; $display("FAIL ignored_go_rem got=%h exp=%h", r, 32'd1); end
    endtask

    task automatic test_back_to_back();
        int lat, bad;
        logic [31:0] q, r, hq;
        start_go(1'b0, 32'd50, 32'd6);
        wait_done(0, lat, bad, q, r, hq);
        checks += 2;
        if (lat !== 35) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=35", lat); end
        if (q !== 32'd8) begin failures++; $display("FAIL b2b_first_quot got=%h exp=%h", q, 32'd8); end
        start_go(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done(0, lat, bad, q, r, hq);
        checks += 5;
        if (lat !== 35) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=35", lat); end
        if (bad !== 0) begin failures++; $display("FAIL b2b_second_stall badcycles=%0d exp=0", bad); end
        if (hq !== 32'd8) begin failures++; $display("FAIL b2b_hold_quot got=%h exp=%h", hq, 32'd8); end
        if (q !== 32'hFFFF_FFF2) begin failures++; $display("FAIL b2b_second_quot got=%h exp=fffffff2", q); end
        if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL b2b_second_rem got=%h exp=fffffffe", r); end
    endtask

    task automatic test_reset_mid();
        int lat, bad, ndone;
        logic [31:0] q, r, hq;
        start_go(1'b0, 32'd12345, 32'd11);
        repeat (19) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks += 4;
        if (stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", stall); end
        if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
        if (quot !== 32'd0) begin failures++; $display("FAIL midreset_quot got=%h exp=0", quot); end
        if (rem !== 32'd0) begin failures++; $display("FAIL midreset_rem got=%h exp=0", rem); end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
        start_go(1'b0, 32'd12345, 32'd11);
        wait_done(0, lat, bad, q, r, hq);
        checks += 3;
        if (lat !== 35) begin failures++; $display("FAIL postreset_latency got=%0d exp=35", lat); end
        if (q !== 32'd1122) begin failures++; $display("FAIL postreset_quot got=%h exp=%h", q, 32'd1122); end
        if (r !== 32'd3) begin failures++; $display("FAIL postreset_rem got=%h exp=%h", r, 32'd3); end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN;
            4: return MAX;
            5: return 32'($urandom_range(0, 40));
            6: return -32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int lat, bad;
        logic [31:0] q, r, hq, a, b, eq, er;
        logic sg;
        for (int i = 0; i < 1000; i++) begin
            a  = pick();
            b  = pick();
            sg = 1'($urandom);
            model(sg, a, b, eq, er);
            start_go(sg, a, b);
            wait_done(0, lat, bad, q, r, hq);
            checks += 4;
            if (lat !== 35) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=35", i, lat); end
            if (bad !== 0) begin failures++; $display("FAIL rand%0d_stall badcycles=%0d exp=0", i, bad); end
            if (q !== eq) begin failures++; $display("FAIL rand%0d_quot s=%b a=%h b=%h got=%h exp=%h", i, sg, a, b, q, eq); end
            if (r !== er) begin failures++; $display("FAIL rand%0d_rem s=%b a=%h b=%h got=%h exp=%h", i, sg, a, b, r, er); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_ignored_go();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
